mem_lipo_sched: RTL
===================

# mem_lipo_sched

Scheduler for the single-port line-in / parallel-out pixel buffer: accepts a stream of 32-pixel line writes and block-read commands (4x4/8x8/16x16/32x32, luma or chroma) and time-multiplexes them onto the buffer's single port. The buffer's port A (write) and port B (read) are never enabled in the same cycle. For each read command it expands the block into the correct sequence of row indices and tags returned data with valid/last. Sits between the original-pixel fetch engine (writer) and the intra/transform consumers (reader).

## Interface
- STARVE_LIMIT, 8: cycles a pending read beat may be blocked by writes before it is forced through
- PIXEL_WIDTH, 8: bits per pixel
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- w_valid  in  1  line write request
- w_ready  out  1  line write accepted this cycle
- w_addr  in  8  line address
- w_data  in  32*PIXEL_WIDTH  line pixels
- rd_start  in  1  block read command; accepted only when rd_ready=1
- rd_ready  out  1  scheduler idle, can take a command
- rd_sel  in  2  0 luma, 1 chroma
- rd_size  in  2  00 4x4, 01 8x8, 10 16x16, 11 32x32
- rd_x, rd_y  in  4 each  top-left 4x4 coordinate
- rd_valid  out  1  buffer read data valid this cycle
- rd_last  out  1  final beat of block (qualified by rd_valid)
- mem_a_wen  out  1  buffer port A write enable
- mem_a_addr  out  8  = w_addr
- mem_a_wdata  out  32*PIXEL_WIDTH  = w_data
- mem_b_ren  out  1  buffer port B read enable
- mem_b_sel, mem_b_size, mem_b_x, mem_b_y, mem_b_idx  out  2,2,4,4,5  latched command fields plus row index

## Operation
- FSM: IDLE, READ. IDLE: rd_ready=1; rd_start latches sel/size/x/y, clears beat counter k, sets wait counter to 0, moves to READ. READ: one read beat pending per cycle until all beats issued; then back to IDLE.
- Beats per size: 4x4 1, 8x8 2, 16x16 8, 32x32 32. mem_b_idx = k*S, S: 4x4 0, 8x8 4, 16x16 2, 32x32 1 (5-bit, no overflow).
- Arbitration each cycle: write granted (w_ready=mem_a_wen=1) when w_valid=1 and either no read beat pending or wait<STARVE_LIMIT; otherwise pending read beat granted (mem_b_ren=1, k++). mem_a_wen & mem_b_ren never both 1.
- wait counter: increments when read beat pending and not granted (saturates at STARVE_LIMIT); clears on read grant. At STARVE_LIMIT the read is granted even if w_valid=1; w_ready=0 that cycle.
- In IDLE writes always granted when w_valid.
- rd_valid = mem_b_ren delayed one cycle; rd_last = delayed (mem_b_ren & k==beats-1).
- rd_start while READ ignored (rd_ready=0). rd_start in the cycle the last beat issues is ignored; FSM is IDLE next cycle.

## Timing
- Reset: FSM IDLE, k=0, wait=0, rd_ready=1, w_ready=0, mem_a_wen=0, mem_b_ren=0, rd_valid=0, rd_last=0, latched fields 0.
- w_ready/mem_a_wen combinational from w_valid and state/wait; write lands same cycle.
- rd_start accepted at T: earliest mem_b_ren at T+1, rd_valid at T+2. Uncontended 32x32: mem_b_ren T+1..T+32, rd_valid T+2..T+33, rd_last at T+33, rd_ready=1 from T+33.
- Read data has no backpressure; consumer must absorb every rd_valid beat.
- Reset mid-block: abandon immediately, all outputs to reset values, no rd_last issued; an in-flight rd_valid is dropped.

## Structure
- Shared package: size codes (I_4x4..I_32x32), beats-per-size and idx-step constants, FSM state encoding.
- One natural sub-module: mem_lipo_rd_seq (beat counter k, idx generation, last detection); arbitration and valid pipeline in top.

## Test plan
- Reset, then rd_start size=00 x=3 y=5 sel=0, w_valid=0 -> one mem_b_ren at T+1 with idx=0, x=3, y=5; rd_valid+rd_last at T+2.
- rd_start size=10, no writes -> 8 consecutive mem_b_ren, idx 0,2,...,14; rd_last only on 8th rd_valid.
- w_valid held 1 during 32x32 read, STARVE_LIMIT=8 -> 8 write cycles, 1 read, repeating; wait never exceeds 8; never mem_a_wen&mem_b_ren; 32 rd_valid total.
- Write burst of 20 lines in IDLE -> w_ready=1 all 20 cycles, mem_a_addr tracks w_addr.
- rd_start pulsed while READ for size=01 -> ignored; only 2 beats, idx 0,4.
- rst_n low after 10th beat of 32x32 -> outputs at reset values at once; rd_ready=1 after release; new command runs normally from idx 0.

Source files
------------

// File: rtl/mem_lipo_sched_pkg.sv
// Shared types and constants for the line-in / parallel-out buffer scheduler.
// Block-size codes, FSM encoding, beat count and row-index step per size.
package mem_lipo_sched_pkg;

  typedef enum logic [1:0] {
    I_4x4   = 2'd0,
    I_8x8   = 2'd1,
    I_16x16 = 2'd2,
    I_32x32 = 2'd3
  } blk_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } sched_state_e;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned RD_LAT = 1;

  typedef struct packed {
    logic [1:0] sel;
    blk_size_e  size;
    logic [3:0] x;
    logic [3:0] y;
  } rd_cmd_t;

  function automatic logic [IDX_W-1:0] beats_m1(blk_size_e s);
    case (s)
      I_4x4:   return 5'd0;
      I_8x8:   return 5'd1;
      I_16x16: return 5'd7;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [2:0] idx_step(blk_size_e s);
    case (s)
      I_4x4:   return 3'd0;
      I_8x8:   return 3'd4;
      I_16x16: return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lipo_sched_if.sv
// Writer, block-read command/response and buffer port bundle for mem_lipo_sched.
// slave = scheduler view, master = surrounding fetch engine / consumer / buffer view.
interface mem_lipo_sched_if #(
  parameter int unsigned PIXEL_WIDTH = 8
);
  localparam int unsigned LINE_W = 32 * PIXEL_WIDTH;

  logic              w_valid;
  logic              w_ready;
  logic [7:0]        w_addr;
  logic [LINE_W-1:0] w_data;

  logic              rd_start;
  logic              rd_ready;
  logic [1:0]        rd_sel;
  logic [1:0]        rd_size;
  logic [3:0]        rd_x;
  logic [3:0]        rd_y;
  logic              rd_valid;
  logic              rd_last;

  logic              mem_a_wen;
  logic [7:0]        mem_a_addr;
  logic [LINE_W-1:0] mem_a_wdata;
  logic              mem_b_ren;
  logic [1:0]        mem_b_sel;
  logic [1:0]        mem_b_size;
  logic [3:0]        mem_b_x;
  logic [3:0]        mem_b_y;
  logic [4:0]        mem_b_idx;

  modport slave (
    input  w_valid, w_addr, w_data, rd_start, rd_sel, rd_size, rd_x, rd_y,
    output w_ready, rd_ready, rd_valid, rd_last,
           mem_a_wen, mem_a_addr, mem_a_wdata,
           mem_b_ren, mem_b_sel, mem_b_size, mem_b_x, mem_b_y, mem_b_idx
  );

  modport master (
    output w_valid, w_addr, w_data, rd_start, rd_sel, rd_size, rd_x, rd_y,
    input  w_ready, rd_ready, rd_valid, rd_last,
           mem_a_wen, mem_a_addr, mem_a_wdata,
           mem_b_ren, mem_b_sel, mem_b_size, mem_b_x, mem_b_y, mem_b_idx
  );

endinterface

// File: rtl/mem_lipo_rd_seq.sv
// Block-read beat sequencer: beat counter k, row index k*step, final-beat flag.
// k restarts at 0 on a new command and wraps to 0 after the final beat.
module mem_lipo_rd_seq
  import mem_lipo_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             adv_i,
  input  blk_size_e        size_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] k_q, k_d;
  logic [7:0]       prod;

  assign last_o = (k_q == beats_m1(size_i));
  // largest product is 31*1 or 7*2, so the 5-bit index never wraps
  assign prod   = 8'(k_q) * 8'(idx_step(size_i));
  assign idx_o  = prod[IDX_W-1:0];

  always_comb begin
    k_d = k_q;
    if (start_i)     k_d = '0;
    else if (adv_i)  k_d = last_o ? '0 : k_q + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) k_q <= '0;
    else        k_q <= k_d;

endmodule

// File: rtl/mem_lipo_sched.sv
// Single-port buffer scheduler: writes win until a pending read beat has waited
// STARVE_LIMIT cycles, then the read is forced through; read data tagged valid/last.
module mem_lipo_sched
  import mem_lipo_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned PIXEL_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_lipo_sched_if.slave    bus
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LINE_W = 32 * PIXEL_WIDTH;

  sched_state_e       state_q, state_d;
  rd_cmd_t            cmd_q, cmd_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               pend, w_gnt, r_gnt, start_acc, beat_last;
  logic [IDX_W-1:0]   idx;
  logic [RD_LAT-1:0]  vld_pipe_q, last_pipe_q;

  mem_lipo_rd_seq u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_acc),
    .adv_i   (r_gnt),
    .size_i  (cmd_q.size),
    .idx_o   (idx),
    .last_o  (beat_last)
  );

  // every READ cycle carries exactly one pending beat
  assign pend  = (state_q == ST_READ);
  assign w_gnt = bus.w_valid && (!pend || (wait_q < WAIT_W'(STARVE_LIMIT)));
  assign r_gnt = pend && !w_gnt;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    wait_d    = wait_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.rd_start) begin
        start_acc = 1'b1;
        cmd_d     = '{sel: bus.rd_sel, size: blk_size_e'(bus.rd_size),
                      x: bus.rd_x, y: bus.rd_y};
        wait_d    = '0;
        state_d   = ST_READ;
      end
      ST_READ: begin
        if (r_gnt) begin
          wait_d = '0;
          if (beat_last) state_d = ST_IDLE;
        end else if (wait_q < WAIT_W'(STARVE_LIMIT)) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      wait_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wait_q      <= wait_d;
      vld_pipe_q  <= (RD_LAT)'({vld_pipe_q, r_gnt});
      last_pipe_q <= (RD_LAT)'({last_pipe_q, r_gnt & beat_last});
    end

  assign bus.w_ready     = w_gnt;
  assign bus.rd_ready    = (state_q == ST_IDLE);
  assign bus.rd_valid    = vld_pipe_q[RD_LAT-1];
  assign bus.rd_last     = last_pipe_q[RD_LAT-1];
  assign bus.mem_a_wen   = w_gnt;
  assign bus.mem_a_addr  = bus.w_addr;
  assign bus.mem_a_wdata = (LINE_W)'(bus.w_data);
  assign bus.mem_b_ren   = r_gnt;
  assign bus.mem_b_sel   = cmd_q.sel;
  assign bus.mem_b_size  = cmd_q.size;
  assign bus.mem_b_x     = cmd_q.x;
  assign bus.mem_b_y     = cmd_q.y;
  assign bus.mem_b_idx   = idx;

endmodule
